// File: rtl/fir_seq_pkg.sv
// Shared state encoding, strobe bundle and default sizing for the FIR tap sequencer.
package fir_seq_pkg;

    localparam int NTAPS_DEF   = 64;
    localparam int AW_DEF      = 6;
    localparam int MAC_LAT_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    typedef struct packed {
        logic dmem_we;
        logic mac_clr;
        logic mac_en;
        logic dout_valid;
        logic busy;
    } seq_strb_t;

    // Strobes are decoded from the state being entered so they leave a flop
    // aligned with that state.
    function automatic seq_strb_t strb_for(seq_state_e nxt, seq_state_e cur);
        seq_strb_t s;
        s            = '0;
        s.dmem_we    = (nxt == ST_WRITE);
        s.mac_en     = (nxt == ST_RUN);
        s.mac_clr    = (nxt == ST_RUN) && (cur == ST_WRITE);
        s.dout_valid = (nxt == ST_DONE);
        s.busy       = (nxt != ST_IDLE);
        return s;
    endfunction

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Control/address bundle between the tap sequencer and host/datapath.
// Perf counters exist only when FIR_TAP_SEQ_PERF_EN is defined.
interface fir_tap_sequencer_if #(
    parameter int AW = fir_seq_pkg::AW_DEF
);
    logic          enable;
    logic          sample_tick;
    logic          overrun_clr;
    logic          cw_req;
    logic [AW-1:0] cw_addr;
    logic          cw_ack;
    logic          cmem_we;
    logic [AW-1:0] cmem_addr;
    logic          dmem_we;
    logic [AW-1:0] dmem_waddr;
    logic [AW-1:0] dmem_raddr;
    logic          mac_clr;
    logic          mac_en;
    logic          dout_valid;
    logic          busy;
    logic          overrun;
`ifdef FIR_TAP_SEQ_PERF_EN
    logic [15:0]   sample_cnt;
    logic [15:0]   drop_cnt;
`endif

    modport master (
        output enable, sample_tick, overrun_clr, cw_req, cw_addr,
`ifdef FIR_TAP_SEQ_PERF_EN
        input  sample_cnt, drop_cnt,
`endif
        input  cw_ack, cmem_we, cmem_addr, dmem_we, dmem_waddr, dmem_raddr,
               mac_clr, mac_en, dout_valid, busy, overrun
    );

    modport slave (
        input  enable, sample_tick, overrun_clr, cw_req, cw_addr,
`ifdef FIR_TAP_SEQ_PERF_EN
        output sample_cnt, drop_cnt,
`endif
        output cw_ack, cmem_we, cmem_addr, dmem_we, dmem_waddr, dmem_raddr,
               mac_clr, mac_en, dout_valid, busy, overrun
    );

endinterface

// File: rtl/fir_tap_addr_gen.sv
// Ring write pointer and tap counter; produces registered CMEM/DMEM tap addresses.
module fir_tap_addr_gen
    import fir_seq_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          step_i,
    input  logic          advance_i,
    output logic [AW-1:0] wptr_o,
    output logic [AW-1:0] k_o,
    output logic [AW-1:0] raddr_o,
    output logic          last_o
);
    localparam logic [AW-1:0] K_LAST = AW'(NTAPS - 1);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] k_q, k_d;
    logic [AW-1:0] raddr_q, raddr_d;

    // raddr tracks wptr-k incrementally; AW-bit wrap gives the ring modulo.
    always_comb begin
        wptr_d  = wptr_q;
        k_d     = k_q;
        raddr_d = raddr_q;
        if (start_i) begin
            k_d     = '0;
            raddr_d = wptr_q;
        end else if (step_i) begin
            k_d     = k_q + 1'b1;
            raddr_d = raddr_q - 1'b1;
        end
        if (advance_i) begin
            wptr_d = wptr_q + 1'b1;
            k_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            k_q     <= '0;
            raddr_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            k_q     <= k_d;
            raddr_q <= raddr_d;
        end
    end

    assign wptr_o  = wptr_q;
    assign k_o     = k_q;
    assign raddr_o = raddr_q;
    assign last_o  = (k_q == K_LAST);

endmodule

// File: rtl/fir_tap_sequencer.sv
// Per-sample FIR control: DMEM ring write, tap walk with MAC strobes, drain, dout_valid.
// Define FIR_TAP_SEQ_PERF_EN to add saturating sample_cnt/drop_cnt counters.
module fir_tap_sequencer
    import fir_seq_pkg::*;
#(
    parameter int NTAPS   = NTAPS_DEF,
    parameter int AW      = AW_DEF,
    parameter int MAC_LAT = MAC_LAT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    fir_tap_sequencer_if.slave bus
);
    localparam int            DW         = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(MAC_LAT - 1);

    seq_state_e    state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;
    seq_strb_t     strb_q, strb_d;
    logic          overrun_q, overrun_d;
    logic          start, step, advance, tap_last;
    logic          grant, tick_drop;
    logic [AW-1:0] wptr, tap_k, tap_raddr;

    fir_tap_addr_gen #(
        .NTAPS (NTAPS),
        .AW    (AW)
    ) u_addr (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start),
        .step_i    (step),
        .advance_i (advance),
        .wptr_o    (wptr),
        .k_o       (tap_k),
        .raddr_o   (tap_raddr),
        .last_o    (tap_last)
    );

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        start   = 1'b0;
        step    = 1'b0;
        advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.sample_tick && bus.enable) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                start   = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (tap_last) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    step = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) state_d = ST_DONE;
                else                       drain_d = drain_q + 1'b1;
            end
            ST_DONE: begin
                advance = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        strb_d = strb_for(state_d, state_q);
    end

    // Host writes only slip in while idle and no sample is arriving; the
    // host keeps cw_req up until it sees cw_ack.
    assign grant     = (state_q == ST_IDLE) && bus.cw_req && !bus.sample_tick;
    assign tick_drop = bus.sample_tick && (state_q != ST_IDLE);

    always_comb begin
        overrun_d = overrun_q;
        if (tick_drop)            overrun_d = 1'b1;
        else if (bus.overrun_clr) overrun_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            drain_q   <= '0;
            strb_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            strb_q    <= strb_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.cw_ack     = grant;
    assign bus.cmem_we    = grant;
    assign bus.cmem_addr  = grant ? bus.cw_addr : tap_k;
    assign bus.dmem_we    = strb_q.dmem_we;
    assign bus.dmem_waddr = wptr;
    assign bus.dmem_raddr = tap_raddr;
    assign bus.mac_clr    = strb_q.mac_clr;
    assign bus.mac_en     = strb_q.mac_en;
    assign bus.dout_valid = strb_q.dout_valid;
    assign bus.busy       = strb_q.busy;
    assign bus.overrun    = overrun_q;

`ifdef FIR_TAP_SEQ_PERF_EN
    logic [15:0] sample_cnt_q, drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt_q <= '0;
            drop_cnt_q   <= '0;
        end else if (bus.overrun_clr) begin
            sample_cnt_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            if (strb_q.dout_valid && (sample_cnt_q != 16'hFFFF)) sample_cnt_q <= sample_cnt_q + 16'd1;
            if (tick_drop && (drop_cnt_q != 16'hFFFF))           drop_cnt_q   <= drop_cnt_q + 16'd1;
        end
    end

    assign bus.sample_cnt = sample_cnt_q;
    assign bus.drop_cnt   = drop_cnt_q;
`endif

endmodule
